// File: rtl/vicharak_core_mc.sv
// rtl/vicharak_core_mc.sv - multi-cycle vicharak test CPU (FETCH/DECODE/EXEC/MEM/WB)
// Optional MUL/DIV hardware is enabled by defining MULDIV_EN.
module vicharak_core_mc #(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [18:0]       prog_wdata,
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc,
  output logic [31:0]       retire_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b00011;
  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_INC  = 5'b00101;
  localparam logic [4:0] OP_DEC  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_NAND = 5'b01001;
  localparam logic [4:0] OP_NOR  = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_XNOR = 5'b01100;
  localparam logic [4:0] OP_JMP  = 5'b01101;
  localparam logic [4:0] OP_BEQ  = 5'b01110;
  localparam logic [4:0] OP_BNE  = 5'b01111;
  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [18:0]       r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] r_regs [NREGS];

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [18:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_res;
  logic [DA_W-1:0]   r_addr;
  logic              r_illegal;
  logic [31:0]       r_retire;

  logic [4:0]        w_op;
  logic [3:0]        w_f1;
  logic              w_busy;
  logic              w_illegal_op;
  logic [DATA_W-1:0] w_alu;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_br_tgt;
  logic [PC_W-1:0]   w_jmp_tgt;
  logic [DA_W-1:0]   w_ea;
  logic [31:0]       w_retire_nxt;

  assign w_op         = r_ir[18:14];
  assign w_f1         = r_ir[13:10];
  assign w_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_br_tgt     = r_pc + PC_W'($signed(r_ir[5:0]));
  assign w_jmp_tgt    = PC_W'(r_ir[13:0]);
  assign w_ea         = DA_W'(r_a) + DA_W'(r_ir[5:0]);
  assign w_retire_nxt = (r_retire == 32'hFFFF_FFFF) ? r_retire : r_retire + 32'd1;

  assign busy       = w_busy;
  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;
  assign pc         = r_pc;
  assign retire_cnt = r_retire;
  assign dbg_rdata  = r_regs[dbg_raddr];

  always_comb begin
    w_illegal_op = 1'b1;
    case (w_op)
      OP_NOP, OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_NAND, OP_NOR,
      OP_XOR, OP_XNOR, OP_JMP, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_HALT: w_illegal_op = 1'b0;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV: w_illegal_op = 1'b0;
`endif
      default: w_illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
`ifdef MULDIV_EN
      OP_MUL:  w_alu = r_a * r_b;
      OP_DIV:  w_alu = (r_b == '0) ? '1 : r_a / r_b;
`endif
      OP_INC:  w_alu = r_a + DATA_W'(1);
      OP_DEC:  w_alu = r_a - DATA_W'(1);
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_NAND: w_alu = ~(r_a & r_b);
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_XNOR: w_alu = ~(r_a ^ r_b);
      default: w_alu = '0;
    endcase
  end

  // Program memory accepts writes whenever the core is not executing.
  always_ff @(posedge clk) begin
    if (prog_we && !w_busy)
      r_imem[prog_addr] <= prog_wdata;
  end

  // Reset wins over a store that would land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_MEM) && (w_op == OP_SW))
      r_dmem[r_addr] <= r_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_res     <= '0;
      r_addr    <= '0;
      r_illegal <= 1'b0;
      r_retire  <= '0;
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_c <= r_regs[r_ir[13:10]];
          r_a <= r_regs[r_ir[9:6]];
          r_b <= r_regs[r_ir[5:2]];
          if (w_op == OP_HALT) begin
            r_state <= S_HALT;
          end else if (w_illegal_op) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (w_op)
            OP_NOP, OP_JMP, OP_BEQ, OP_BNE: begin
              if (w_op == OP_JMP)
                r_pc <= w_jmp_tgt;
              else if ((w_op == OP_BEQ) && (r_c == r_a))
                r_pc <= w_br_tgt;
              else if ((w_op == OP_BNE) && (r_c != r_a))
                r_pc <= w_br_tgt;
              else
                r_pc <= w_pc_inc;
              r_retire <= w_retire_nxt;
              r_state  <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              r_addr  <= w_ea;
              r_state <= S_MEM;
            end
            default: begin
              r_res   <= w_alu;
              r_state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (w_op == OP_SW) begin
            r_pc     <= w_pc_inc;
            r_retire <= w_retire_nxt;
            r_state  <= S_FETCH;
          end else begin
            r_res   <= r_dmem[r_addr];
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_f1 != 4'd0)
            r_regs[w_f1] <= r_res;
          r_pc     <= w_pc_inc;
          r_retire <= w_retire_nxt;
          r_state  <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_illegal <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vicharak_core_mc.sv
// tb/tb_vicharak_core_mc.sv - directed table-driven bench for vicharak_core_mc
// Define MULDIV_EN for both bench and RTL to exercise MUL/DIV.
module tb_vicharak_core_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [18:0] prog_wdata;
  logic [3:0]  dbg_raddr;
  logic [15:0] dbg_rdata;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [7:0]  pc;
  logic [31:0] retire_cnt;

  vicharak_core_mc dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .busy(busy),
    .halted(halted), .illegal(illegal), .pc(pc), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011;
  localparam logic [4:0] DIV = 5'b00100, INC = 5'b00101, DEC = 5'b00110, AND = 5'b00111;
  localparam logic [4:0] OR = 5'b01000, NAND = 5'b01001, NOR = 5'b01010, XOR = 5'b01011;
  localparam logic [4:0] XNOR = 5'b01100, BNE = 5'b01111, LW = 5'b10000, SW = 5'b10001;
  localparam logic [4:0] HALT = 5'b11111;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    bit          ill;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] prog[$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [18:0] enc(input logic [4:0] op, input logic [3:0] f1, f2, f3);
    return {op, f1, f2, f3, 2'b00};
  endfunction

  function automatic logic [18:0] enci(input logic [4:0] op, input logic [3:0] f1, f2, input logic [5:0] imm);
    return {op, f1, f2, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Builds value v in register r using only AND/INC/ADD (shift-and-set).
  task automatic emit_const(input logic [3:0] r, input logic [15:0] v);
    bit found = 0;
    prog.push_back(enc(AND, r, 4'd0, 4'd0));
    for (int i = 15; i >= 0; i--) begin
      if (found) prog.push_back(enc(ADD, r, r, r));
      if (v[i]) begin
        prog.push_back(enc(INC, r, r, 4'd0));
        found = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_wdata = prog[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!halted) chk("halt_timeout", 32'(cyc), 32'd5000 + 32'd1);
  endtask

  task automatic run_prog(output int cyc);
    pulse_start();
    wait_halt(cyc);
  endtask

  task automatic rd_reg(input logic [3:0] r, output logic [15:0] v);
    dbg_raddr = r; #1;
    v = dbg_rdata;
  endtask

  logic [15:0] v;
  logic [18:0] first;
  int          cyc;

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; dbg_raddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_illegal", 32'(illegal), 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_retire", retire_cnt, 0);
    rd_reg(4'd5, v); chk("reset_r5", 32'(v), 0);

    vecs.push_back('{ADD,  16'h1234, 16'h0F0F, 16'h2143, 0});
    vecs.push_back('{ADD,  16'h8000, 16'h8000, 16'h0000, 0});
    vecs.push_back('{SUB,  16'h0005, 16'h0007, 16'hFFFE, 0});
    vecs.push_back('{AND,  16'hF0F0, 16'h3C3C, 16'h3030, 0});
    vecs.push_back('{OR,   16'hF0F0, 16'h3C3C, 16'hFCFC, 0});
    vecs.push_back('{NAND, 16'hF0F0, 16'h3C3C, 16'hCFCF, 0});
    vecs.push_back('{NOR,  16'hF0F0, 16'h3C3C, 16'h0303, 0});
    vecs.push_back('{XOR,  16'hF0F0, 16'h3C3C, 16'hCCCC, 0});
    vecs.push_back('{XNOR, 16'hF0F0, 16'h3C3C, 16'h3333, 0});
    vecs.push_back('{INC,  16'hFFFF, 16'h0003, 16'h0000, 0});
    vecs.push_back('{DEC,  16'h0000, 16'h0003, 16'hFFFF, 0});
`ifdef MULDIV_EN
    vecs.push_back('{MUL,  16'd300,  16'd300,  16'h5F90, 0});
    vecs.push_back('{DIV,  16'h1234, 16'h0000, 16'hFFFF, 0});
    vecs.push_back('{DIV,  16'd100,  16'd7,    16'h000E, 0});
`else
    vecs.push_back('{MUL,  16'd300,  16'd300,  16'h0000, 1});
    vecs.push_back('{DIV,  16'd100,  16'd7,    16'h0000, 1});
`endif

    foreach (vecs[k]) begin
      do_reset();
      prog.delete();
      emit_const(4'd1, vecs[k].a);
      emit_const(4'd2, vecs[k].b);
      prog.push_back(enc(vecs[k].op, 4'd3, 4'd1, 4'd2));
      prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
      load_prog();
      run_prog(cyc);
      chk($sformatf("vec%0d_illegal", k), 32'(illegal), 32'(vecs[k].ill));
      chk($sformatf("vec%0d_retire", k), retire_cnt, 32'(prog.size() - (vecs[k].ill ? 2 : 1)));
      if (!vecs[k].ill) begin
        rd_reg(4'd3, v); chk($sformatf("vec%0d_r3", k), 32'(v), 32'(vecs[k].exp));
      end
    end

    // Seed DMEM[0]=5, DMEM[1]=7, DMEM[5]=2 for the load tests.
    do_reset();
    prog.delete();
    prog.push_back(enc(INC, 4'd1, 4'd0, 4'd0));
    prog.push_back(enc(INC, 4'd1, 4'd1, 4'd0));
    prog.push_back(enc(ADD, 4'd1, 4'd1, 4'd1));
    prog.push_back(enc(INC, 4'd1, 4'd1, 4'd0));
    prog.push_back(enci(SW, 4'd1, 4'd0, 6'd0));
    prog.push_back(enc(INC, 4'd2, 4'd1, 4'd0));
    prog.push_back(enc(INC, 4'd2, 4'd2, 4'd0));
    prog.push_back(enci(SW, 4'd2, 4'd0, 6'd1));
    prog.push_back(enc(INC, 4'd4, 4'd0, 4'd0));
    prog.push_back(enc(INC, 4'd4, 4'd4, 4'd0));
    prog.push_back(enci(SW, 4'd4, 4'd0, 6'd5));
    prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
    load_prog();
    run_prog(cyc);
    chk("seed_retire", retire_cnt, 11);

    // LW/LW/ADD/HALT; imem[0] is written in the same cycle as start.
    do_reset();
    prog.delete();
    prog.push_back(enci(LW, 4'd1, 4'd0, 6'd0));
    prog.push_back(enci(LW, 4'd2, 4'd0, 6'd1));
    prog.push_back(enc(ADD, 4'd3, 4'd1, 4'd2));
    prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
    first = prog[0];
    prog[0] = enc(HALT, 4'd0, 4'd0, 4'd0);
    load_prog();
    prog_we = 1'b1; prog_addr = 8'd0; prog_wdata = first; start = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    chk("lw_cycles", 32'(cyc), 16);
    rd_reg(4'd3, v); chk("lw_add_r3", 32'(v), 12);
    chk("lw_retire", retire_cnt, 3);
    chk("lw_halted", 32'(halted), 1);
    chk("lw_illegal", 32'(illegal), 0);

    // r0 stays zero; INC of 0xFFFF wraps.
    do_reset();
    prog.delete();
    emit_const(4'd1, 16'hFFFF);
    prog.push_back(enc(INC, 4'd2, 4'd1, 4'd0));
    prog.push_back(enc(ADD, 4'd0, 4'd1, 4'd1));
    prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
    load_prog();
    run_prog(cyc);
    rd_reg(4'd2, v); chk("wrap_r2", 32'(v), 0);
    rd_reg(4'd0, v); chk("r0_zero", 32'(v), 0);

    // Countdown loop: 4 setup instructions, then DEC/BNE three times.
    do_reset();
    prog.delete();
    emit_const(4'd1, 16'd3);
    prog.push_back(enc(DEC, 4'd1, 4'd1, 4'd0));
    prog.push_back(enci(BNE, 4'd1, 4'd0, 6'h3F));
    prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
    load_prog();
    run_prog(cyc);
    rd_reg(4'd1, v); chk("loop_r1", 32'(v), 0);
    chk("loop_retire", retire_cnt, 10);
    chk("loop_pc", 32'(pc), 6);

    // Illegal opcode at pc=2, then restart clears the flag.
    do_reset();
    prog.delete();
    prog.push_back(enc(NOP, 4'd0, 4'd0, 4'd0));
    prog.push_back(enc(NOP, 4'd0, 4'd0, 4'd0));
    prog.push_back(enc(5'b10101, 4'd0, 4'd0, 4'd0));
    load_prog();
    run_prog(cyc);
    chk("ill_halted", 32'(halted), 1);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_pc", 32'(pc), 2);
    chk("ill_retire", retire_cnt, 2);
    pulse_start();
    chk("restart_illegal", 32'(illegal), 0);
    chk("restart_pc", 32'(pc), 0);
    chk("restart_busy", 32'(busy), 1);
    wait_halt(cyc);
    chk("rerun_illegal", 32'(illegal), 1);
    chk("rerun_retire", retire_cnt, 4);

    // Reset lands on the MEM cycle of SW r1,[r0+5]: the store must not happen.
    do_reset();
    prog.delete();
    prog.push_back(enc(INC, 4'd1, 4'd0, 4'd0));
    prog.push_back(enci(SW, 4'd1, 4'd0, 6'd5));
    prog.push_back(enc(HALT, 4'd0, 4'd0, 4'd0));
    load_prog();
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_halted", 32'(halted), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_retire", retire_cnt, 0);
    rd_reg(4'd1, v); chk("midrst_r1", 32'(v), 0);
    prog.delete();
    prog.push_back(enci(LW, 4'd2, 4'd0, 6'd5));
    prog.push_back(enc(NOP, 4'd0, 4'd0, 4'd0));
    load_prog();
    run_prog(cyc);
    rd_reg(4'd2, v); chk("dmem_unwritten", 32'(v), 2);
    chk("imem_kept_pc", 32'(pc), 2);
    chk("imem_kept_illegal", 32'(illegal), 0);
    chk("imem_kept_retire", retire_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
